// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM state type and line-metadata type for the
// direct-mapped write-back data cache (dcache_ctrl and dcache_sram).
//   Geometry: 32 lines x 256 bits, 32-bit byte addresses, 32-bit words.
//   Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2].
package dcache_pkg;

  localparam int unsigned NUM_LINES  = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned INDEX_W    = $clog2(NUM_LINES);
  localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_t;

  // Line-aligned byte address of a given tag/index pair.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                      input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty and data storage for the data cache.
//   clk, rst    : clock, asynchronous active-high reset (clears valid/dirty only)
//   index       : line select shared by the read port and the write port
//   meta, rdata : combinational read of the selected line's metadata and data
//   line_we     : whole-line write (refill): data, tag, valid=1, dirty=0
//   word_we     : single-word write (store hit): one word, dirty=1
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = NUM_LINES,
  parameter int unsigned LINE_BITS = LINE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index,
  output line_t                 meta,
  output logic [LINE_BITS-1:0]  rdata,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_BITS-1:0]  line_wdata,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     word_wdata
);

  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;

  assign meta  = '{valid: valid[index], dirty: dirty[index], tag: tag_mem[index]};
  assign rdata = data_mem[index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (word_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[index] <= line_wdata;
      tag_mem[index]  <= line_tag;
    end else if (word_we) begin
      data_mem[index][word_sel*WORD_W +: WORD_W] <= word_wdata;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   p1_addr_i, p1_data_i    : CPU byte address and store data
//   p1_MemRead_i/MemWrite_i : load/store request (both high = store)
//   p1_data_o, p1_stall_o   : load data on hit; stall while a request misses
//   mem_addr_o, mem_data_o  : registered line address / write-back line
//   mem_enable_o, mem_write_o : registered request valid / 1 = line write
//   mem_data_i, mem_ack_i   : refill line and one-cycle completion pulse
// Hits complete in the request cycle. A miss stalls, optionally writes the
// dirty victim back, refills the line, passes through REFILL_DONE and then
// the held request hits in IDLE.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = NUM_LINES,
  parameter int unsigned LINE_BITS = LINE_W,
  parameter int unsigned ADDR_W    = ADDR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_e                 state;
  logic [INDEX_W-1:0]     miss_index;
  logic [TAG_W-1:0]       miss_tag;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_W-1:0]     req_index;
  logic [WORD_SEL_W-1:0]  word_sel;
  logic                   req;
  logic                   tag_hit;
  logic                   hit;
  logic                   miss;
  logic [INDEX_W-1:0]     sram_index;
  line_t                  meta;
  logic [LINE_BITS-1:0]   rdata;
  logic                   line_we;
  logic                   word_we;
  logic                   unused_byte_sel;

  assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_index       = p1_addr_i[OFFSET_W +: INDEX_W];
  assign word_sel        = p1_addr_i[2 +: WORD_SEL_W];
  assign unused_byte_sel = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;

  // Outside IDLE the array is addressed by the latched miss, so an in-flight
  // transaction still completes if the CPU drops its request.
  assign sram_index = (state == IDLE) ? req_index : miss_index;

  // Only IDLE may hit: REFILL_DONE deliberately stalls one more cycle, and
  // keeping hits out of the other states leaves the write port to the refill.
  assign tag_hit = meta.valid && (meta.tag == req_tag);
  assign hit     = (state == IDLE) && req && tag_hit;
  assign miss    = (state == IDLE) && req && !tag_hit;

  assign p1_stall_o = req && !hit;
  assign word_we    = hit && p1_MemWrite_i;
  assign line_we    = (state == REFILL) && mem_ack_i;

  always_comb begin
    p1_data_o = '0;
    if (hit) begin
      p1_data_o = rdata[word_sel*WORD_W +: WORD_W];
    end
  end

  dcache_sram #(
    .LINES    (LINES),
    .LINE_BITS(LINE_BITS)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .index     (sram_index),
    .meta      (meta),
    .rdata     (rdata),
    .line_we   (line_we),
    .line_tag  (miss_tag),
    .line_wdata(mem_data_i),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_wdata(p1_data_i)
  );

  // Memory-side outputs are registered and held until mem_ack_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      miss_index   <= '0;
      miss_tag     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_index   <= req_index;
            miss_tag     <= req_tag;
            mem_enable_o <= 1'b1;
            if (meta.valid && meta.dirty) begin
              state       <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= line_addr(meta.tag, req_index);
              mem_data_o  <= rdata;
            end else begin
              state       <= REFILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= line_addr(req_tag, req_index);
            end
          end
        end
        WRITEBACK: begin
          // Victim written: go straight on to the refill read, enable held.
          if (mem_ack_i) begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= line_addr(miss_tag, miss_index);
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state        <= REFILL_DONE;
            mem_enable_o <= 1'b0;
          end
        end
        REFILL_DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a
// fixed-latency line memory model (10 cycles per request).
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  p1_addr = '0;
  logic [31:0]  p1_wdata = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  p1_rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_en;
  logic         mem_we;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  bit mem_auto = 1'b1;
  int mem_lat  = 10;
  int mem_cnt  = 0;
  logic [255:0] bmem [int unsigned];

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .p1_addr_i    (p1_addr),
    .p1_data_i    (p1_wdata),
    .p1_MemRead_i (rd),
    .p1_MemWrite_i(wr),
    .p1_data_o    (p1_rdata),
    .p1_stall_o   (stall),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_we),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  // Default backing contents: word i of line A is {A[15:0], i}.
  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 16'(i)};
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return pattern(a);
  endfunction

  // Memory model: ack on the mem_lat-th cycle of an asserted enable.
  always @(negedge clk) begin
    if (mem_auto) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end
      if (mem_en) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          mem_ack = 1'b1;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = mem_line(mem_addr);
        end
      end else begin
        mem_cnt = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Present a request at posedge+1; returns at posedge+4 of that cycle.
  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic r,
                         input logic w);
    @(posedge clk);
    #1;
    p1_addr  = a;
    p1_wdata = d;
    rd       = r;
    wr       = w;
    #3;
  endtask

  task automatic cpu_idle();
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    #3;
  endtask

  // Walk a stalled request until it hits, recording the memory traffic.
  task automatic run_miss(output int stalls, output int rd_en, output int wr_en,
                          output logic [31:0] rd_addr, output logic [31:0] wb_addr,
                          output logic [255:0] wb_data, output bit timeout);
    stalls = 0; rd_en = 0; wr_en = 0;
    rd_addr = '0; wb_addr = '0; wb_data = '0; timeout = 1'b0;
    while (stall) begin
      if (stalls >= 200) begin
        timeout = 1'b1;
        break;
      end
      stalls++;
      if (mem_en && mem_we) begin
        wr_en++;
        wb_addr = mem_addr;
        wb_data = mem_wdata;
      end
      if (mem_en && !mem_we) begin
        rd_en++;
        rd_addr = mem_addr;
      end
      @(posedge clk);
      #4;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #4;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (p1_rdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", p1_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_enable got %0b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_write got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin
      errors++; $display("FAIL reset_mem_bus got addr %h data %h want 0", mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_refill_load();
    int s, re, we; logic [31:0] ra, wa; logic [255:0] wd; bit to;
    cpu_req(32'h48, 32'h0, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL refill_first_stall got %0b want 1", stall); end
    run_miss(s, re, we, ra, wa, wd, to);
    checks++; if (to || s != 12) begin errors++; $display("FAIL refill_stall_cycles got %0d want 12", s); end
    checks++; if (re != 10 || we != 0) begin
      errors++; $display("FAIL refill_mem_cycles got rd %0d wr %0d want rd 10 wr 0", re, we);
    end
    checks++; if (ra !== 32'h40) begin errors++; $display("FAIL refill_addr got %h want 00000040", ra); end
    checks++; if (p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL refill_data got %h want deadbeef", p1_rdata);
    end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL refill_enable_drop got %0b want 0", mem_en); end
    cpu_idle();
  endtask

  task automatic test_hit_load();
    cpu_req(32'h48, 32'h0, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall got %0b want 0", stall); end
    checks++; if (p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hit_data got %h want deadbeef", p1_rdata);
    end
    cpu_idle();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL hit_enable got %0b want 0", mem_en); end
    checks++; if (p1_rdata !== 32'h0) begin errors++; $display("FAIL idle_data got %h want 0", p1_rdata); end
  endtask

  task automatic test_store_hit();
    cpu_req(32'h4C, 32'h12345678, 1'b0, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_hit_stall got %0b want 0", stall); end
    cpu_idle();
    cpu_req(32'h4C, 32'h0, 1'b1, 1'b0);
    checks++; if (p1_rdata !== 32'h12345678) begin
      errors++; $display("FAIL store_hit_readback got %h want 12345678", p1_rdata);
    end
    checks++; if (dut.u_sram.dirty[2] !== 1'b1) begin
      errors++; $display("FAIL store_hit_dirty got %0b want 1", dut.u_sram.dirty[2]);
    end
    cpu_idle();
    cpu_req(32'h48, 32'h0, 1'b1, 1'b0);
    checks++; if (p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_hit_neighbour got %h want deadbeef", p1_rdata);
    end
    cpu_idle();
  endtask

  task automatic test_writeback();
    int s, re, we; logic [31:0] ra, wa; logic [255:0] wd; bit to;
    logic [255:0] stored;
    cpu_req(32'h448, 32'h0, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wb_first_stall got %0b want 1", stall); end
    run_miss(s, re, we, ra, wa, wd, to);
    checks++; if (to || s != 22) begin errors++; $display("FAIL wb_stall_cycles got %0d want 22", s); end
    checks++; if (we != 10 || re != 10) begin
      errors++; $display("FAIL wb_mem_cycles got wr %0d rd %0d want 10 10", we, re);
    end
    checks++; if (wa !== 32'h40) begin errors++; $display("FAIL wb_addr got %h want 00000040", wa); end
    checks++; if (wd[127:96] !== 32'h12345678 || wd[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wb_data got w3 %h w2 %h want 12345678 deadbeef", wd[127:96], wd[95:64]);
    end
    checks++; if (ra !== 32'h440) begin errors++; $display("FAIL wb_refill_addr got %h want 00000440", ra); end
    checks++; if (p1_rdata !== 32'h04400002) begin
      errors++; $display("FAIL wb_load_data got %h want 04400002", p1_rdata);
    end
    stored = mem_line(32'h40);
    checks++; if (stored[127:96] !== 32'h12345678) begin
      errors++; $display("FAIL wb_memory_word got %h want 12345678", stored[127:96]);
    end
    checks++; if (dut.u_sram.dirty[2] !== 1'b0) begin
      errors++; $display("FAIL wb_clean_after got %0b want 0", dut.u_sram.dirty[2]);
    end
    cpu_idle();
  endtask

  task automatic test_store_miss();
    int s, re, we; logic [31:0] ra, wa; logic [255:0] wd; bit to;
    cpu_req(32'h800, 32'hCAFEF00D, 1'b0, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL smiss_first_stall got %0b want 1", stall); end
    run_miss(s, re, we, ra, wa, wd, to);
    checks++; if (to || s != 12 || we != 0 || re != 10) begin
      errors++; $display("FAIL smiss_cycles got stall %0d wr %0d rd %0d want 12 0 10", s, we, re);
    end
    checks++; if (ra !== 32'h800) begin errors++; $display("FAIL smiss_addr got %h want 00000800", ra); end
    cpu_idle();
    cpu_req(32'h800, 32'h0, 1'b1, 1'b0);
    checks++; if (p1_rdata !== 32'hCAFEF00D || stall !== 1'b0) begin
      errors++; $display("FAIL smiss_merged got %h stall %0b want cafef00d 0", p1_rdata, stall);
    end
    checks++; if (dut.u_sram.dirty[0] !== 1'b1) begin
      errors++; $display("FAIL smiss_dirty got %0b want 1", dut.u_sram.dirty[0]);
    end
    cpu_idle();
    cpu_req(32'h804, 32'h0, 1'b1, 1'b0);
    checks++; if (p1_rdata !== 32'h08000001) begin
      errors++; $display("FAIL smiss_other_word got %h want 08000001", p1_rdata);
    end
    cpu_idle();
    // Read and write together is a store.
    cpu_req(32'h808, 32'h55AA55AA, 1'b1, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_stall got %0b want 0", stall); end
    cpu_idle();
    cpu_req(32'h808, 32'h0, 1'b1, 1'b0);
    checks++; if (p1_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL rw_is_write got %h want 55aa55aa", p1_rdata);
    end
    cpu_idle();
  endtask

  task automatic test_reset_mid_refill();
    int s, re, we; logic [31:0] ra, wa; logic [255:0] wd; bit to;
    mem_auto = 1'b0;
    cpu_req(32'h48, 32'h0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL mid_refill_active got en %0b addr %h want 1 00000040", mem_en, mem_addr);
    end
    rst = 1'b1;
    rd  = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset got en %0b addr %h want 0 0", mem_en, mem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mem_rdata = pattern(32'h0);
    mem_ack   = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #3;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL late_ack_enable got %0b want 0", mem_en); end
    checks++; if (dut.u_sram.dirty[0] !== 1'b0) begin
      errors++; $display("FAIL reset_dirty_clear got %0b want 0", dut.u_sram.dirty[0]);
    end
    mem_auto = 1'b1;
    cpu_req(32'h48, 32'h0, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL post_reset_miss got %0b want 1", stall); end
    run_miss(s, re, we, ra, wa, wd, to);
    checks++; if (to || s != 12 || re != 10 || we != 0) begin
      errors++; $display("FAIL post_reset_cycles got stall %0d rd %0d wr %0d want 12 10 0", s, re, we);
    end
    checks++; if (p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL post_reset_data got %h want deadbeef", p1_rdata);
    end
    cpu_idle();
  endtask

  initial begin
    logic [255:0] l;
    l = pattern(32'h40);
    l[95:64] = 32'hDEADBEEF;
    bmem[32'h40] = l;
    test_reset();
    test_refill_load();
    test_hit_load();
    test_store_hit();
    test_writeback();
    test_store_miss();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
